// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory request/acknowledge bus between the fetch
//               stage (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage feeding the IF/ID register. Owns the
//               PC, runs a variable-latency req/ack handshake to instruction
//               memory, parks results during stalls and discards responses
//               made stale by a redirect.
// Options     : FETCH_PERF_EN adds saturating fetched/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  wire logic        clk_i,
  input  wire logic        rst_n_i,
  input  wire logic        stall_i,
  input  wire logic        redirect_i,
  input  wire logic [15:0] redirect_pc_i,
  fetch_stage_if.master    imem,
  output logic      [15:0] pc_o,
  output logic      [15:0] pc_plus4_o,
  output logic      [31:0] inst_o,
  output logic             ifid_load_o,
  output logic             ifid_flush_o
`ifdef FETCH_PERF_EN
  ,
  output logic      [31:0] perf_fetched_o,
  output logic      [31:0] perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] pcp_q, pcp_d;
  logic [15:0] disc_q, disc_d;

  // Word-aligned redirect target; the low two bits are forced to zero.
  logic [15:0] w_target;
  logic [15:0] w_pc_plus4;

  assign w_target   = redirect_pc_i & ~16'h0003;
  assign w_pc_plus4 = pc_q + 16'd4;  // wraps modulo 2^16
  assign pc_o       = pc_q;

  // Bus and IF/ID outputs; request/load/flush are held low while in reset.
  always_comb begin
    imem.imem_req  = rst_n_i && (state_q != HOLD);
    imem.imem_addr = (state_q == DISCARD) ? disc_q : pc_q;
    pc_plus4_o     = (state_q == HOLD) ? pcp_q : w_pc_plus4;
    inst_o         = (state_q == HOLD) ? inst_q : imem.imem_data;
    ifid_flush_o   = rst_n_i && redirect_i;
    ifid_load_o    = rst_n_i && !redirect_i && !stall_i &&
                     (((state_q == FETCH) && imem.imem_ack) || (state_q == HOLD));
  end

  // Next-state logic; priority is redirect, then stall, then ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcp_d   = pcp_q;
    disc_d  = disc_q;
    case (state_q)
      FETCH: begin
        if (redirect_i) begin
          pc_d = w_target;
          if (!imem.imem_ack) begin
            // Request still in flight: remember its address so it can be
            // completed and its response thrown away.
            disc_d  = pc_q;
            state_d = DISCARD;
          end
        end else if (imem.imem_ack) begin
          pc_d = w_pc_plus4;
          if (stall_i) begin
            inst_d  = imem.imem_data;
            pcp_d   = w_pc_plus4;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_d    = w_target;
          state_d = FETCH;
        end else if (!stall_i) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_i) begin
          pc_d = w_target;
        end
        if (imem.imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pcp_q   <= 16'h0;
      disc_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcp_q   <= pcp_d;
      disc_q  <= disc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating increments for the performance counters.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (ifid_load_o && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (stall_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage with a small
//               configurable-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [15:0] pc_plus4;
  logic [31:0] inst;
  logic        ifid_load;
  logic        ifid_flush;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model controls: ack arrives in the lat-th cycle of a request.
  logic mem_en;
  int   lat;
  int   cnt;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (bus),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .inst_o        (inst),
    .ifid_load_o   (ifid_load),
    .ifid_flush_o  (ifid_flush)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o(perf_fetched),
    .perf_stall_o  (perf_stall)
`endif
  );

  function automatic logic [31:0] mdata(input logic [15:0] a);
    return {~a, a};
  endfunction

  assign bus.imem_ack  = mem_en && bus.imem_req && (cnt == lat - 1);
  assign bus.imem_data = mdata(bus.imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (!bus.imem_req || bus.imem_ack || !mem_en) cnt <= 0;
    else cnt <= cnt + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    mem_en = 1'b1; lat = 3;
    #2 rst_n = 1'b0;
    redirect = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b want 0", ifid_load); end
    n_checks++; if (ifid_flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", ifid_flush); end
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", pc); end
    redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
        n_fail++; $display("FAIL lat_req_addr[%0d]: got req=%b addr=%h want 1/0000", i, bus.imem_req, bus.imem_addr); end
      n_checks++; if (ifid_load !== (i == 2)) begin
        n_fail++; $display("FAIL lat_load[%0d]: got %b want %b", i, ifid_load, (i == 2)); end
      if (i < 2) tick();
    end
    n_checks++; if (inst !== 32'hFFFF_0000) begin n_fail++; $display("FAIL lat_inst: got %h want ffff0000", inst); end
    tick();
    lat = 1;
  endtask

  task automatic test_zero_latency;
    logic [15:0] exp_a [3];
    exp_a[0] = 16'h0004; exp_a[1] = 16'h0008; exp_a[2] = 16'h000C;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.imem_addr !== exp_a[i]) begin n_fail++; $display("FAIL z_addr[%0d]: got %h want %h", i, bus.imem_addr, exp_a[i]); end
      n_checks++; if (ifid_load !== 1'b1) begin n_fail++; $display("FAIL z_load[%0d]: got %b want 1", i, ifid_load); end
      n_checks++; if (pc_plus4 !== exp_a[i] + 16'd4) begin n_fail++; $display("FAIL z_pcp4[%0d]: got %h want %h", i, pc_plus4, exp_a[i] + 16'd4); end
      tick();
    end
    mem_en = 1'b0;
  endtask

  task automatic test_stall_hold;
    mem_en = 1'b1; stall = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010 || ifid_load !== 1'b0) begin
      n_fail++; $display("FAIL st_ack: got req=%b addr=%h load=%b want 1/0010/0", bus.imem_req, bus.imem_addr, ifid_load); end
    tick(); #1;
    n_checks++; if (bus.imem_req !== 1'b0 || ifid_load !== 1'b0) begin
      n_fail++; $display("FAIL st_hold: got req=%b load=%b want 0/0", bus.imem_req, ifid_load); end
    n_checks++; if (inst !== 32'hFFEF_0010 || pc_plus4 !== 16'h0014) begin
      n_fail++; $display("FAIL st_held: got inst=%h pcp4=%h want ffef0010/0014", inst, pc_plus4); end
    n_checks++; if (pc !== 16'h0014) begin n_fail++; $display("FAIL st_pc: got %h want 0014", pc); end
    @(negedge clk);
    stall = 1'b0;
    #1;
    n_checks++; if (ifid_load !== 1'b1 || inst !== 32'hFFEF_0010 || pc_plus4 !== 16'h0014 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL st_release: got load=%b inst=%h pcp4=%h req=%b want 1/ffef0010/0014/0", ifid_load, inst, pc_plus4, bus.imem_req); end
    tick();
    mem_en = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0014 || ifid_load !== 1'b0) begin
      n_fail++; $display("FAIL st_next: got req=%b addr=%h load=%b want 1/0014/0", bus.imem_req, bus.imem_addr, ifid_load); end
  endtask

  task automatic test_redirect_discard;
    @(negedge clk);
    mem_en = 1'b1; lat = 1;
    tick(); tick(); tick();
    lat = 2; redirect = 1'b1; redirect_pc = 16'h0103;
    #1;
    n_checks++; if (ifid_flush !== 1'b1 || ifid_load !== 1'b0 || bus.imem_addr !== 16'h0020 || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL rd_cycle: got flush=%b load=%b addr=%h req=%b want 1/0/0020/1", ifid_flush, ifid_load, bus.imem_addr, bus.imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0020 || bus.imem_ack !== 1'b1) begin
      n_fail++; $display("FAIL rd_disc_addr: got req=%b addr=%h ack=%b want 1/0020/1", bus.imem_req, bus.imem_addr, bus.imem_ack); end
    n_checks++; if (ifid_load !== 1'b0 || ifid_flush !== 1'b0) begin
      n_fail++; $display("FAIL rd_disc_load: got load=%b flush=%b want 0/0", ifid_load, ifid_flush); end
    n_checks++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL rd_pc: got %h want 0100", pc); end
    tick();
    mem_en = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100 || ifid_load !== 1'b0) begin
      n_fail++; $display("FAIL rd_next: got req=%b addr=%h load=%b want 1/0100/0", bus.imem_req, bus.imem_addr, ifid_load); end
  endtask

  task automatic test_reset_mid_request;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0 || ifid_load !== 1'b0) begin
      n_fail++; $display("FAIL mr_req: got req=%b load=%b want 0/0", bus.imem_req, ifid_load); end
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL mr_pc: got %h want 0000", pc); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL mr_restart: got req=%b addr=%h want 1/0000", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    mem_en = 1'b1; lat = 1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    #1;
    n_checks++; if (ifid_flush !== 1'b1 || ifid_load !== 1'b0) begin
      n_fail++; $display("FAIL wr_redir: got flush=%b load=%b want 1/0", ifid_flush, ifid_load); end
    tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (pc !== 16'hFFFC || bus.imem_addr !== 16'hFFFC) begin
      n_fail++; $display("FAIL wr_pc: got pc=%h addr=%h want fffc/fffc", pc, bus.imem_addr); end
    n_checks++; if (ifid_load !== 1'b1 || pc_plus4 !== 16'h0000 || inst !== 32'h0003_FFFC) begin
      n_fail++; $display("FAIL wr_load: got load=%b pcp4=%h inst=%h want 1/0000/0003fffc", ifid_load, pc_plus4, inst); end
    tick();
    mem_en = 1'b0;
    #1;
    n_checks++; if (pc !== 16'h0000 || bus.imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL wr_after: got pc=%h addr=%h want 0000/0000", pc, bus.imem_addr); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; mem_en = 1'b1; lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mem_en = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b0;
    #1;
    n_checks++; if (perf_fetched !== 32'd5) begin n_fail++; $display("FAIL perf_fetched: got %0d want 5", perf_fetched); end
    n_checks++; if (perf_stall !== 32'd3) begin n_fail++; $display("FAIL perf_stall: got %0d want 3", perf_stall); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_fetched, perf_stall); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_zero_latency();
    test_stall_hold();
    test_redirect_discard();
    test_reset_mid_request();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
